// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds the accepted operand beat, S2 holds the
// registered result and flags. An internal accumulator can stand in for A.
module alu_pipe #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op_code,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero
);

  localparam int XW = WIDTH + 2;

  typedef enum logic [1:0] {
    OP_SHADD = 2'b00,
    OP_ADD3  = 2'b01,
    OP_NEG   = 2'b10,
    OP_ABS   = 2'b11
  } op_e;

  logic             s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0] s1A_q, s1A_d;
  logic [WIDTH-1:0] s1B_q, s1B_d;
  op_e              s1Op_q, s1Op_d;
  logic             s1Sel_q, s1Sel_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2Adv, xfer, accept;
  logic [WIDTH-1:0] opA, res;
  logic             resCout;
  logic [XW-1:0]    aExt, bExt, sum3, diff, absd;

  // S1 can refill in the same cycle it drains into S2, giving one op per cycle.
  always_comb begin
    s2Adv    = !outValid_q || out_ready;
    xfer     = s1Valid_q && s2Adv;
    in_ready = !rst && (!s1Valid_q || xfer);
    accept   = in_valid && in_ready;
  end

  // The two wide ops use WIDTH+2 bits so the carry/overflow and the sign of 2A-B survive.
  always_comb begin
    opA     = s1Sel_q ? acc_q : s1A_q;
    aExt    = {2'b00, opA};
    bExt    = {2'b00, s1B_q};
    sum3    = aExt + (bExt << 1) + bExt;
    diff    = (aExt << 1) - bExt;
    absd    = diff[XW-1] ? -diff : diff;
    res     = '0;
    resCout = 1'b0;
    case (s1Op_q)
      OP_SHADD: res = (opA << 2) + (s1B_q >> 1);
      OP_ADD3: begin
        res     = sum3[WIDTH-1:0];
        resCout = |sum3[XW-1:WIDTH];
      end
      OP_NEG:   res = '0 - s1B_q;
      OP_ABS: begin
        res     = absd[WIDTH-1:0];
        resCout = |absd[XW-1:WIDTH];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Op_d     = s1Op_q;
    s1Sel_d    = s1Sel_q;
    outValid_d = outValid_q;
    out_d      = out_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    acc_d      = acc_q;

    if (accept) begin
      s1Valid_d = 1'b1;
      s1A_d     = A;
      s1B_d     = B;
      s1Op_d    = op_e'(op_code);
      s1Sel_d   = acc_sel;
    end else if (xfer) begin
      s1Valid_d = 1'b0;
    end

    if (xfer) begin
      outValid_d = 1'b1;
      out_d      = res;
      cout_d     = resCout;
      zero_d     = (res == '0);
      acc_d      = res;
    end else if (s2Adv) begin
      outValid_d = 1'b0;
    end

    // A clear wins over the transfer update; the transferring op already used the old value.
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Op_q     <= OP_SHADD;
      s1Sel_q    <= 1'b0;
      outValid_q <= 1'b0;
      out_q      <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Op_q     <= s1Op_d;
      s1Sel_q    <= s1Sel_d;
      outValid_q <= outValid_d;
      out_q      <= out_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = outValid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a queue-based behavioural model checked every cycle,
// directed beats with hand-computed results, then a randomized stream.
module tb_alu_pipe;

  localparam int W   = 6;
  localparam int MOD = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [1:0]   op_code = 2'b00;
  logic         acc_sel = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         cout;
  logic         zero;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op_code(op_code), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .cout(cout), .zero(zero)
  );

  typedef struct { int a; int b; int op; int sel; } beat_t;
  typedef struct { int out; int cout; int zero; } res_t;

  int passCount  = 0;
  int checkCount = 0;

  beat_t s1q[$];
  res_t  obs[$];
  bit    mOutValid = 0;
  res_t  mRes;
  int    mAcc = 0;
  bit    started = 0;
  bit    collect = 0;

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
  endtask

  // Results from the arithmetic rules alone, using plain integers.
  function automatic res_t compute(input beat_t bt, input int acc);
    res_t r;
    int a, s, d;
    a = bt.sel ? acc : bt.a;
    r.cout = 0;
    case (bt.op)
      0: r.out = (a * 4 + bt.b / 2) % MOD;
      1: begin s = a + 3 * bt.b; r.out = s % MOD; r.cout = (s >= MOD); end
      2: r.out = (MOD - bt.b) % MOD;
      default: begin
        d = 2 * a - bt.b;
        if (d < 0) d = -d;
        r.out = d % MOD;
        r.cout = (d >= MOD);
      end
    endcase
    r.zero = (r.out == 0);
    return r;
  endfunction

  // Model: at most one beat waits in S1; a presented result leaves when the consumer takes it.
  always @(posedge clk) begin
    bit adv, xfer, rdy;
    int accNext;
    beat_t bt;
    started = 1;
    if (rst) begin
      s1q.delete();
      mOutValid = 0;
      mAcc = 0;
    end else begin
      adv  = !mOutValid || out_ready;
      xfer = (s1q.size() > 0) && adv;
      rdy  = (s1q.size() == 0) || xfer;
      accNext = mAcc;
      if (xfer) begin
        bt = s1q.pop_front();
        mRes = compute(bt, mAcc);
        mOutValid = 1;
        accNext = mRes.out;
      end else if (adv) begin
        mOutValid = 0;
      end
      if (acc_clr) accNext = 0;
      mAcc = accNext;
      if (in_valid && rdy)
        s1q.push_back('{a: int'(A), b: int'(B), op: int'(op_code), sel: int'(acc_sel)});
    end
  end

  // Every-cycle comparison against the model, plus collection of consumed results.
  always @(negedge clk) begin
    bit expRdy;
    if (started) begin
      expRdy = !rst && ((s1q.size() == 0) || !mOutValid || out_ready);
      checkVal("in_ready", in_ready, expRdy);
      checkVal("out_valid", out_valid, mOutValid);
      if (mOutValid) begin
        checkVal("out", out, mRes.out);
        checkVal("cout", cout, mRes.cout);
        checkVal("zero", zero, mRes.zero);
      end
      if (rst) obs.delete();
      else if (collect && out_valid && out_ready)
        obs.push_back('{out: int'(out), cout: int'(cout), zero: int'(zero)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one beat and holds it until accepted, bounded to 50 cycles.
  task automatic applyStimulus(input int a, input int b, input int op, input int sel);
    int n;
    bit r;
    n = 0;
    A = W'(a); B = W'(b); op_code = 2'(op); acc_sel = 1'(sel);
    acc_clr = 1'b0;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      r = in_ready;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) checkVal("accept timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic clrCycle();
    in_valid = 1'b0;
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  task automatic waitObs(input int n);
    int k;
    k = 0;
    while (obs.size() < n && k < 100) begin
      tick();
      k++;
    end
    if (obs.size() < n) checkVal("result timeout", obs.size(), n);
  endtask

  task automatic checkOutput(input string name, input int eo, input int ec, input int ez);
    res_t r;
    if (obs.size() == 0) begin
      checkVal({name, " present"}, 0, 1);
      return;
    end
    r = obs.pop_front();
    checkVal({name, " out"}, r.out, eo);
    checkVal({name, " cout"}, r.cout, ec);
    checkVal({name, " zero"}, r.zero, ez);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx, accepts;
    bit r;

    rst = 1'b1;
    tick();
    tick();
    checkVal("reset out_valid", out_valid, 0);
    checkVal("reset out", out, 0);
    checkVal("reset cout", cout, 0);
    checkVal("reset zero", zero, 0);
    checkVal("reset in_ready", in_ready, 0);
    rst = 1'b0;
    collect = 1'b1;
    out_ready = 1'b1;

    A = 5; B = 6; op_code = 0; acc_sel = 0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("latency accept cycle", out_valid, 0);
    tick();
    @(negedge clk);
    checkVal("latency result cycle", out_valid, 1);
    tick();
    waitObs(1);
    checkOutput("op00 5,6", 23, 0, 0);

    applyStimulus(63, 1, 1, 0);
    applyStimulus(10, 3, 1, 0);
    waitObs(2);
    checkOutput("op01 63,1", 2, 1, 0);
    checkOutput("op01 10,3", 19, 0, 0);

    applyStimulus(0, 0, 2, 0);
    applyStimulus(0, 1, 2, 0);
    waitObs(2);
    checkOutput("op10 B=0", 0, 0, 1);
    checkOutput("op10 B=1", 63, 0, 0);

    applyStimulus(3, 20, 3, 0);
    applyStimulus(40, 0, 3, 0);
    applyStimulus(10, 20, 3, 0);
    waitObs(3);
    checkOutput("op11 3,20", 14, 0, 0);
    checkOutput("op11 40,0", 16, 1, 0);
    checkOutput("op11 10,20", 0, 0, 1);

    clrCycle();
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    clrCycle();
    applyStimulus(0, 1, 1, 1);
    waitObs(5);
    checkOutput("chain 1", 3, 0, 0);
    checkOutput("chain 2", 6, 0, 0);
    checkOutput("chain 3", 9, 0, 0);
    checkOutput("chain 4 with clear", 12, 0, 0);
    checkOutput("after clear", 3, 0, 0);

    out_ready = 1'b0;
    idx = 0;
    accepts = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      A = W'(idx + 1); B = 0; op_code = 0; acc_sel = 0;
      in_valid = (idx < 4);
      @(negedge clk);
      r = in_ready;
      tick();
      if (r && in_valid) begin
        idx++;
        accepts++;
      end
    end
    checkVal("stall accepts", accepts, 2);
    @(negedge clk);
    checkVal("stall hold valid", out_valid, 1);
    checkVal("stall hold out", out, 4);
    tick();
    out_ready = 1'b1;
    while (idx < 4) begin
      applyStimulus(idx + 1, 0, 0, 0);
      idx++;
    end
    waitObs(4);
    checkOutput("stall order 1", 4, 0, 0);
    checkOutput("stall order 2", 8, 0, 0);
    checkOutput("stall order 3", 12, 0, 0);
    checkOutput("stall order 4", 16, 0, 0);

    out_ready = 1'b0;
    applyStimulus(1, 1, 1, 0);
    applyStimulus(2, 1, 1, 0);
    A = 3; B = 1; op_code = 1; in_valid = 1'b1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkVal("mid reset out_valid", out_valid, 0);
    checkVal("mid reset in_ready", in_ready, 0);
    tick();
    @(negedge clk);
    checkVal("held reset in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    applyStimulus(0, 1, 1, 1);
    waitObs(1);
    checkOutput("acc after reset", 3, 0, 0);

    collect = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      A         = W'($urandom);
      B         = W'($urandom);
      op_code   = 2'($urandom);
      acc_sel   = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      acc_clr   = ($urandom % 10) == 0;
      rst       = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor of the 6-bit four-op ALU.
- Same op set: shift-add, A+3B, negate, abs(2A−B), generalised to WIDTH bits.
- Adds a 2-stage valid/ready pipeline with backpressure, an internal accumulator usable as operand A, and carry/overflow and zero flags.
- Sits between an operand producer and a result consumer; sustains one operation per cycle when not stalled.

Parameters:
- WIDTH, 6, operand/result width in bits (≥ 3).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- op_code  input  2  00 shift-add, 01 add3, 10 neg, 11 abs
- acc_sel  input  1  1 = use accumulator in place of A
- acc_clr  input  1  synchronous clear of accumulator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- cout  output  1  carry/overflow flag
- zero  output  1  out == 0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: s1_valid=0, out_valid=0, out=0, cout=0, zero=0, acc=0. in_ready is forced 0 while rst=1.
- Stage 1 (S1) registers A, B, op_code and acc_sel on accept. Accept = in_valid && in_ready.
- Compute is combinational from S1 (A replaced by acc when acc_sel) into stage 2 (S2) registers out/cout/zero.
- Advance conditions:
  - S2 advances when !out_valid || out_ready.
  - S1→S2 transfer happens when s1_valid && S2 advances.
  - in_ready = !s1_valid || (S1→S2 transfer this cycle).
- Latency: out_valid rises 2 cycles after the accept edge when unstalled. Throughput is 1 op/cycle.
- Backpressure: while out_valid && !out_ready, out/cout/zero/out_valid hold. No beat is dropped or duplicated, and order is preserved.
- Arithmetic: all results are taken mod 2^WIDTH, with operands zero-extended.
  - 00: (A<<2) + (B>>1), logical shifts, truncated; cout=0.
  - 01: A + 3·B computed at WIDTH+2 bits; cout = 1 iff full sum ≥ 2^WIDTH.
  - 10: −B two's complement; cout=0.
  - 11: d = 2·A − B signed at WIDTH+2 bits; out = low WIDTH bits of |d|; cout = 1 iff |d| ≥ 2^WIDTH.
- zero = (out == 0), registered with out.
- Accumulator:
  - acc <= result on every S1→S2 transfer, regardless of acc_sel.
  - An op in S1 always sees acc including the previous transferred result, so back-to-back acc_sel ops chain with no hazard.
  - acc_clr=1 sets acc to 0 next edge and overrides a same-cycle update; the transferring op still uses the old acc.
- rst mid-operation: all in-flight beats are discarded, the accumulator is cleared, and out_valid=0 on the cycle after the rst edge.
- in_valid while in_ready=0: the beat is not taken. The producer must hold it stable.

Test Plan:
- All tests use WIDTH=6.
- op00 A=5, B=6, out_ready=1 → out=23, cout=0, zero=0, out_valid exactly 2 cycles after accept.
- op01 A=63, B=1 → out=2, cout=1; then A=10, B=3 → out=19, cout=0, back-to-back on consecutive cycles.
- op10 B=0 → out=0, zero=1, cout=0; then B=1 → out=63, zero=0.
- op11 A=3, B=20 → out=14, cout=0; A=40, B=0 → out=16, cout=1; A=10, B=20 → out=0, zero=1.
- Accumulator chaining: pulse acc_clr, then three back-to-back op01 beats with acc_sel=1, B=1 → outs 3, 6, 9. A fourth beat issued with acc_clr in the same cycle as its S1→S2 transfer → out=12 and the next acc_sel op sees acc=0.
- Stall and reset: stream 4 beats with out_ready=0 → in_ready drops after 2 accepts; out holds the first result; on release, results come out in order with none lost. Asserting rst mid-stream → out_valid=0 and acc=0 the next cycle; in_ready=0 while rst is held.
